// File: rtl/keypad_entry_if.sv
// Keypad/timer signal bundle for keypad_entry.
// The master side is the keypad matrix plus the countdown timer.
// The slave side is the entry controller.
interface keypad_entry_if;
   logic [3:0] rows;
   logic       timer_done;
   logic [2:0] cols;
   logic [3:0] digit;
   logic       digit_valid;
   logic       loadn;
   logic       cancel;
   logic [2:0] digit_count;

   modport master (
      output rows,
      output timer_done,
      input  cols,
      input  digit,
      input  digit_valid,
      input  loadn,
      input  cancel,
      input  digit_count
   );

   modport slave (
      input  rows,
      input  timer_done,
      output cols,
      output digit,
      output digit_valid,
      output loadn,
      output cancel,
      output digit_count
   );
endinterface

// File: rtl/keypad_entry.sv
// Keypad entry controller for a 4-digit countdown timer.
// Scans a 4x3 active-low keypad one column at a time and debounces a
// single pressed key. Each key is accepted once per press and applied
// as an entry/run-mode action (digit load, cancel, start).
module keypad_entry #(
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic           CLK,
   input  logic           clear,
   keypad_entry_if.slave  kp
);

   localparam int SDW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DBW = $clog2(DEBOUNCE + 1);
   localparam logic [SDW-1:0] DWELL_LAST = SDW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE - 1);

   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;
   localparam logic [3:0] KEY_NONE = 4'hF;

   typedef enum logic [1:0] {
      S_SCAN     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_HELD     = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       col_q, col_d;
   logic [SDW-1:0]   dwell_q, dwell_d;
   logic [DBW-1:0]   cnt_q, cnt_d;
   logic [3:0]       pat_q, pat_d;
   logic [3:0]       digit_q, digit_d;
   logic             dv_q, dv_d;
   logic             cancel_q, cancel_d;
   logic             loadn_q, loadn_d;
   logic [2:0]       count_q, count_d;

   logic             accept;
   logic [3:0]       key;

   // True when exactly one row line is pulled low.
   function automatic logic one_low(input logic [3:0] r);
      logic res;
      case (r)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
         default:                            res = 1'b0;
      endcase
      return res;
   endfunction

   // Index of the low row in a one-low pattern.
   function automatic logic [1:0] row_of(input logic [3:0] r);
      logic [1:0] res;
      case (r)
         4'b1110: res = 2'd0;
         4'b1101: res = 2'd1;
         4'b1011: res = 2'd2;
         4'b0111: res = 2'd3;
         default: res = 2'd0;
      endcase
      return res;
   endfunction

   // Key code for a row/column position: 0-9 digits, A for '*', B for '#'.
   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] res;
      case ({row, col})
         4'b00_00: res = 4'd1;
         4'b00_01: res = 4'd2;
         4'b00_10: res = 4'd3;
         4'b01_00: res = 4'd4;
         4'b01_01: res = 4'd5;
         4'b01_10: res = 4'd6;
         4'b10_00: res = 4'd7;
         4'b10_01: res = 4'd8;
         4'b10_10: res = 4'd9;
         4'b11_00: res = KEY_STAR;
         4'b11_01: res = 4'd0;
         4'b11_10: res = KEY_HASH;
         default:  res = KEY_NONE;
      endcase
      return res;
   endfunction

   // State and output registers, all forced to idle by clear.
   always_ff @(posedge CLK or posedge clear) begin
      if (clear) begin
         state_q  <= S_SCAN;
         col_q    <= 2'd0;
         dwell_q  <= '0;
         cnt_q    <= '0;
         pat_q    <= 4'hF;
         digit_q  <= 4'd0;
         dv_q     <= 1'b0;
         cancel_q <= 1'b0;
         loadn_q  <= 1'b0;
         count_q  <= 3'd0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         dwell_q  <= dwell_d;
         cnt_q    <= cnt_d;
         pat_q    <= pat_d;
         digit_q  <= digit_d;
         dv_q     <= dv_d;
         cancel_q <= cancel_d;
         loadn_q  <= loadn_d;
         count_q  <= count_d;
      end
   end

   // Scan/debounce/held sequencing and key action decode.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      dwell_d  = dwell_q;
      cnt_d    = cnt_q;
      pat_d    = pat_q;
      digit_d  = digit_q;
      dv_d     = 1'b0;
      cancel_d = 1'b0;
      loadn_d  = loadn_q;
      count_d  = count_q;
      accept   = 1'b0;

      case (state_q)
         S_SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (one_low(kp.rows)) begin
                  // Freeze on the current column and remember the pattern.
                  state_d = S_DEBOUNCE;
                  pat_d   = kp.rows;
                  cnt_d   = '0;
               end else begin
                  col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         S_DEBOUNCE: begin
            if (kp.rows != pat_q) begin
               // Bounce: abandon silently and rescan from the first column.
               state_d = S_SCAN;
               col_d   = 2'd0;
               dwell_d = '0;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               accept  = 1'b1;
               state_d = S_HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HELD: begin
            if (kp.rows == 4'hF) begin
               if (cnt_q == DEB_LAST) begin
                  state_d = S_SCAN;
                  col_d   = 2'd0;
                  dwell_d = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end
         default: begin
            state_d = S_SCAN;
            col_d   = 2'd0;
            dwell_d = '0;
            cnt_d   = '0;
         end
      endcase

      key = key_code(row_of(pat_q), col_q);

      // Timer expiry ends run mode; a '*' on the same edge gives the same
      // register result and additionally the cancel strobe.
      if (loadn_q && kp.timer_done) begin
         loadn_d = 1'b0;
         count_d = 3'd0;
      end

      if (accept) begin
         if (!loadn_q) begin
            if (key <= 4'd9) begin
               if (count_q < 3'd4) begin
                  digit_d = key;
                  dv_d    = 1'b1;
                  count_d = count_q + 3'd1;
               end
            end else if (key == KEY_STAR) begin
               cancel_d = 1'b1;
               count_d  = 3'd0;
            end else if (key == KEY_HASH && count_q != 3'd0) begin
               loadn_d = 1'b1;
            end
         end else if (key == KEY_STAR) begin
            cancel_d = 1'b1;
            loadn_d  = 1'b0;
            count_d  = 3'd0;
         end
      end
   end

   // One-hot active-low column drive from the column index.
   always_comb begin
      case (col_q)
         2'd0:    kp.cols = 3'b110;
         2'd1:    kp.cols = 3'b101;
         2'd2:    kp.cols = 3'b011;
         default: kp.cols = 3'b110;
      endcase
   end

   assign kp.digit       = digit_q;
   assign kp.digit_valid = dv_q;
   assign kp.cancel      = cancel_q;
   assign kp.loadn       = loadn_q;
   assign kp.digit_count = count_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a key-level reference model plus directed key
// sequences, with a per-cycle output comparison and literal spot checks.
module tb_keypad_entry;
   localparam int SD = 4;
   localparam int DB = 3;

   logic       CLK = 1'b0;
   logic       clear = 1'b1;
   logic       td = 1'b0;
   logic       key_down = 1'b0;
   logic       raw_mode = 1'b0;
   logic [3:0] raw_rows = 4'hF;
   int         key_r = 0;
   int         key_c = 0;
   bit         checking = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int dv_log[$];
   int cancel_cnt = 0;

   string KEYS = "123456789*0#";

   keypad_entry_if kp();

   keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .CLK   (CLK),
      .clear (clear),
      .kp    (kp)
   );

   always #5 CLK = ~CLK;

   // Keypad matrix: the pressed key pulls its row low only while its column is driven.
   assign kp.rows = raw_mode ? raw_rows :
                    (key_down && (kp.cols[key_c] == 1'b0)) ? ~(4'b0001 << key_r) : 4'hF;
   assign kp.timer_done = td;

   // ---------------- reference model ----------------
   int         m_phase;   // 0 scanning, 1 confirming, 2 waiting for release
   int         m_t, m_n, m_fcol;
   logic [3:0] m_pat;
   int         m_digit, m_count;
   bit         m_dv, m_cancel, m_loadn;
   logic [2:0] m_cols;

   function automatic int zeros(logic [3:0] r);
      int z = 0;
      for (int i = 0; i < 4; i++) if (r[i] == 1'b0) z++;
      return z;
   endfunction

   function automatic int low_index(logic [3:0] r);
      for (int i = 0; i < 4; i++) if (r[i] == 1'b0) return i;
      return 0;
   endfunction

   always @(posedge CLK or posedge clear) begin
      if (clear) begin
         m_phase = 0; m_t = 0; m_n = 0; m_fcol = 0; m_pat = 4'hF;
         m_digit = 0; m_count = 0; m_dv = 0; m_cancel = 0; m_loadn = 0;
         m_cols = 3'b110;
      end else begin
         byte k;
         bit  acc;
         bit  l0;
         acc = 0; l0 = m_loadn; m_dv = 0; m_cancel = 0; k = "-";
         case (m_phase)
            0: begin
               if ((m_t % SD) == SD - 1 && zeros(kp.rows) == 1) begin
                  m_phase = 1; m_pat = kp.rows; m_fcol = (m_t / SD) % 3; m_n = 0;
               end else m_t++;
            end
            1: begin
               if (kp.rows != m_pat) begin
                  m_phase = 0; m_t = 0;
               end else begin
                  m_n++;
                  if (m_n == DB) begin acc = 1; m_phase = 2; m_n = 0; end
               end
            end
            default: begin
               if (kp.rows == 4'hF) begin
                  m_n++;
                  if (m_n == DB) begin m_phase = 0; m_t = 0; m_n = 0; end
               end else m_n = 0;
            end
         endcase
         if (l0 && td) begin m_loadn = 0; m_count = 0; end
         if (acc) begin
            k = KEYS[3 * low_index(m_pat) + m_fcol];
            if (!l0) begin
               if (k >= "0" && k <= "9") begin
                  if (m_count < 4) begin m_digit = int'(k) - 48; m_dv = 1; m_count++; end
               end else if (k == "*") begin
                  m_cancel = 1; m_count = 0;
               end else if (m_count > 0) begin
                  m_loadn = 1;
               end
            end else if (k == "*") begin
               m_cancel = 1; m_loadn = 0; m_count = 0;
            end
         end
         m_cols = (m_phase == 0) ? ~(3'b001 << ((m_t / SD) % 3)) : ~(3'b001 << m_fcol);
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, plus strobe logging.
   always @(negedge CLK) begin
      if (!clear) begin
         if (kp.digit_valid === 1'b1) dv_log.push_back(int'(kp.digit));
         if (kp.cancel === 1'b1) cancel_cnt++;
      end
      if (!clear && checking) begin
         check("cols", 32'(kp.cols), 32'(m_cols));
         check("digit", 32'(kp.digit), 32'(m_digit));
         check("digit_valid", 32'(kp.digit_valid), 32'(m_dv));
         check("loadn", 32'(kp.loadn), 32'(m_loadn));
         check("cancel", 32'(kp.cancel), 32'(m_cancel));
         check("digit_count", 32'(kp.digit_count), 32'(m_count));
      end
   end

   task automatic set_key(byte k);
      for (int i = 0; i < 12; i++) if (KEYS[i] == k) begin key_r = i / 3; key_c = i % 3; end
   endtask

   task automatic press(byte k, int hold, int rel);
      @(negedge CLK);
      set_key(k);
      key_down = 1'b1;
      repeat (hold) @(negedge CLK);
      key_down = 1'b0;
      repeat (rel) @(negedge CLK);
   endtask

   task automatic wait_phase1(string name);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (m_phase == 1) begin ok = 1; break; end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_cols"}, 32'(kp.cols), 32'(3'b110));
      check({tag, "_digit"}, 32'(kp.digit), 32'd0);
      check({tag, "_dv"}, 32'(kp.digit_valid), 32'd0);
      check({tag, "_loadn"}, 32'(kp.loadn), 32'd0);
      check({tag, "_cancel"}, 32'(kp.cancel), 32'd0);
      check({tag, "_count"}, 32'(kp.digit_count), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      int c0;
      bit found8;

      repeat (3) @(negedge CLK);
      check_reset_outputs("reset");
      clear = 1'b0;
      checking = 1'b1;

      // Four digits.
      press("2", 24, 24);
      press("1", 24, 24);
      press("7", 24, 24);
      press("9", 24, 24);
      check("dv_pulses4", 32'(dv_log.size()), 32'd4);
      if (dv_log.size() == 4) begin
         check("dv0", 32'(dv_log[0]), 32'd2);
         check("dv1", 32'(dv_log[1]), 32'd1);
         check("dv2", 32'(dv_log[2]), 32'd7);
         check("dv3", 32'(dv_log[3]), 32'd9);
      end
      check("digit_9", 32'(kp.digit), 32'd9);
      check("count_4", 32'(kp.digit_count), 32'd4);
      check("loadn_0", 32'(kp.loadn), 32'd0);

      // Fifth digit is ignored.
      press("5", 24, 24);
      check("dv_pulses_after5", 32'(dv_log.size()), 32'd4);
      check("digit_still9", 32'(kp.digit), 32'd9);
      check("count_still4", 32'(kp.digit_count), 32'd4);

      // Row bounce is rejected.
      c0 = cancel_cnt;
      raw_mode = 1'b1;
      raw_rows = 4'b1101;
      wait_phase1("bounce_freeze");
      @(negedge CLK);
      raw_rows = 4'hF;
      @(negedge CLK);
      check("bounce_rescan_col0", 32'(kp.cols), 32'(3'b110));
      raw_rows = 4'b1101;
      @(negedge CLK);
      raw_rows = 4'hF;
      repeat (20) @(negedge CLK);
      raw_mode = 1'b0;
      check("bounce_no_dv", 32'(dv_log.size()), 32'd4);
      check("bounce_no_cancel", 32'(cancel_cnt), 32'(c0));

      // '#' with four digits starts the run; timer expiry ends it.
      @(negedge CLK);
      set_key("#");
      key_down = 1'b1;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (kp.loadn === 1'b1) begin ok = 1; break; end
      end
      check("hash_loadn_rise", 32'(ok), 32'd1);
      repeat (10) @(negedge CLK);
      key_down = 1'b0;
      repeat (24) @(negedge CLK);
      check("run_count_kept", 32'(kp.digit_count), 32'd4);
      td = 1'b1;
      @(negedge CLK);
      td = 1'b0;
      check("timer_loadn", 32'(kp.loadn), 32'd0);
      check("timer_count", 32'(kp.digit_count), 32'd0);
      check("timer_no_cancel", 32'(cancel_cnt), 32'(c0));

      // '#' with nothing entered, then 3, #, *.
      press("#", 24, 24);
      check("hash0_loadn", 32'(kp.loadn), 32'd0);
      check("hash0_count", 32'(kp.digit_count), 32'd0);
      press("3", 24, 24);
      check("digit_3", 32'(kp.digit), 32'd3);
      check("count_1", 32'(kp.digit_count), 32'd1);
      press("#", 24, 24);
      check("hash_run", 32'(kp.loadn), 32'd1);
      @(negedge CLK);
      set_key("*");
      key_down = 1'b1;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (kp.loadn === 1'b0) begin ok = 1; break; end
      end
      check("star_loadn_fall", 32'(ok), 32'd1);
      check("star_cancel_hi", 32'(kp.cancel), 32'd1);
      @(negedge CLK);
      check("star_cancel_lo", 32'(kp.cancel), 32'd0);
      repeat (10) @(negedge CLK);
      key_down = 1'b0;
      repeat (24) @(negedge CLK);
      check("star_count", 32'(kp.digit_count), 32'd0);
      check("star_one_cancel", 32'(cancel_cnt), 32'(c0 + 1));

      // clear during debounce of '8'.
      @(negedge CLK);
      set_key("8");
      key_down = 1'b1;
      wait_phase1("key8_freeze");
      @(posedge CLK);
      #2 clear = 1'b1;
      #1 check_reset_outputs("midclear");
      key_down = 1'b0;
      @(negedge CLK);
      clear = 1'b0;
      #1 check("cols_after_clear", 32'(kp.cols), 32'(3'b110));
      repeat (40) @(negedge CLK);
      found8 = 0;
      foreach (dv_log[i]) if (dv_log[i] == 8) found8 = 1;
      check("no_digit8", 32'(found8), 32'd0);
      check("dv_total", 32'(dv_log.size()), 32'd5);
      check("count_after_clear", 32'(kp.digit_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
